mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: MULT_CYCLES, default 5, busy duration for MULT/MULTU.
REQ-002 Parameter: DIV_CYCLES, default 10, busy duration for DIV/DIVU.
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request from EX stage; qualifies op, rs_val and rt_val.
REQ-006 Port: op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 Port: rs_val  input  32  first operand (multiplicand, dividend, or MTHI/MTLO data).
REQ-008 Port: rt_val  input  32  second operand (multiplier or divisor).
REQ-009 Port: busy  output  1  registered; high while a MULT/DIV operation is in progress.
REQ-010 Port: hi  output  32  registered HI register.
REQ-011 Port: lo  output  32  registered LO register.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 In IDLE, start=1 with op MULT/MULTU/DIV/DIVU SHALL, at that edge:
  - latch the computed result into shadow registers;
  - load the down-counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1 and move to RUN.
REQ-014 In RUN, each edge SHALL decrement the counter.
  - On the edge where the counter equals 1: hi/lo take the shadow values, busy clears, FSM returns to IDLE.
REQ-015 Accept-to-result timing: start accepted at edge t -> busy=1 for exactly N cycles (edges t..t+N) -> new hi/lo visible and busy=0 from edge t+N.
REQ-016 hi/lo SHALL NOT change during RUN before the final edge; mfhi/mflo reads during busy return the old values.
REQ-017 MULT: {hi,lo} SHALL be the signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-018 DIV: lo SHALL be the signed quotient, truncated toward zero; hi SHALL be the remainder, carrying the dividend's sign.
REQ-019 DIVU: lo SHALL be the unsigned quotient and hi the unsigned remainder.
REQ-020 Signed overflow case 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-021 Divisor 0 (DIV or DIVU): busy SHALL still assert for DIV_CYCLES, and hi/lo SHALL be left unchanged at completion.
REQ-022 In IDLE, start=1 with MTHI SHALL write rs_val to hi at that edge with no busy; MTLO SHALL likewise write rs_val to lo.
REQ-023 start=1 while busy=1 (any op) SHALL be ignored: no restart, no hi/lo write, counter unaffected.
REQ-024 start=1 with op 110/111 SHALL have no effect.
REQ-025 Operands SHALL be sampled only at the accept edge; input changes during RUN SHALL have no effect on the result.
REQ-026 A new operation SHALL be acceptable on the first cycle after busy falls; back-to-back operations need no idle gap.

Reset
REQ-027 reset=1 SHALL force hi=0, lo=0, busy=0, counter=0, shadow registers=0, FSM=IDLE at the next edge.
REQ-028 Reset SHALL take priority over start and over completion.
REQ-029 Reset during RUN SHALL abort the operation; hi/lo read 0 and no late write-back occurs.

Verification
REQ-030 The bench SHALL cover MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 The bench SHALL cover MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 The bench SHALL cover DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; repeat as DIVU rs=7, rt=0 -> hi/lo unchanged after 10 cycles.
REQ-033 The bench SHALL cover MTHI 0x12345678 while idle -> hi=0x12345678 next edge, busy stays 0; then, during a running MULT, MTLO 0xDEADBEEF -> ignored, and lo ends as the product.
REQ-034 The bench SHALL cover a start pulse while busy (DIV 100/10 issued during MULT 6*7) -> only the MULT completes (lo=42, hi=0), and busy falls after 5 cycles total.
REQ-035 The bench SHALL cover reset asserted on the 3rd busy cycle of DIV 100/10 -> next edge busy=0, hi=lo=0, and no update follows.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: result computed at accept, held in shadow
// registers, and released to hi/lo after a fixed busy latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        shadow_hi_q, shadow_hi_d;
    logic [31:0]        shadow_lo_q, shadow_lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        safe_s;
    logic [31:0]        safe_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, whose
    // architectural answer (quotient = dividend, remainder 0) is exactly x/1.
    always_comb begin
        prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u   = {32'b0, rs_val} * {32'b0, rt_val};
        div_zero = (rt_val == 32'd0);
        div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        safe_s   = (div_zero || div_ovf) ? 32'd1 : rt_val;
        safe_u   = div_zero ? 32'd1 : rt_val;
        quot_s   = $signed(rs_val) / $signed(safe_s);
        rem_s    = $signed(rs_val) % $signed(safe_s);
        quot_u   = rs_val / safe_u;
        rem_u    = rs_val % safe_u;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {shadow_hi_d, shadow_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor still occupies the unit but writes back the old values.
                            if (div_zero) begin
                                shadow_hi_d = hi_q;
                                shadow_lo_d = lo_q;
                            end else if (op == OP_DIV) begin
                                shadow_hi_d = rem_s;
                                shadow_lo_d = quot_s;
                            end else begin
                                shadow_hi_d = rem_u;
                                shadow_lo_d = quot_u;
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = shadow_hi_q;
                    lo_d    = shadow_lo_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected hi/lo/latency queued at issue,
// popped and compared when busy falls.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl_hi   = '0;
    logic [31:0] mdl_lo   = '0;

    // Reference model: sign-magnitude division, 64-bit integer multiplication.
    function automatic exp_t model(input string name, input logic [2:0] o,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv;
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        e.name = name; e.hi = mdl_hi; e.lo = mdl_lo; e.cycles = 0;
        case (o)
            3'd0: begin
                sa = longint'($signed(a)); sbv = longint'($signed(b));
                p = 64'(sa * sbv);
                {e.hi, e.lo} = p; e.cycles = MULT_N;
            end
            3'd1: begin
                p = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = p; e.cycles = MULT_N;
            end
            3'd2: begin
                e.cycles = DIV_N;
                if (b != 32'd0) begin
                    ma = a[31] ? (~a + 32'd1) : a;
                    mb = b[31] ? (~b + 32'd1) : b;
                    q = ma / mb; r = ma % mb;
                    if (a[31] ^ b[31]) q = ~q + 32'd1;
                    if (a[31]) r = ~r + 32'd1;
                    e.hi = r; e.lo = q;
                end
            end
            3'd3: begin
                e.cycles = DIV_N;
                if (b != 32'd0) begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    // Issue one op at the current negedge; optionally inject a second start on busy cycle 2.
    // Operands are scrambled during RUN to show they are only sampled at accept.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit inj = 1'b0, input logic [2:0] io = 3'd0,
                          input logic [31:0] ia = 32'd0, input logic [31:0] ib = 32'd0);
        exp_t        e;
        int          cnt;
        logic [31:0] old_hi, old_lo;
        e = model(name, o, a, b);
        sb.push_back(e);
        old_hi = mdl_hi; old_lo = mdl_lo;
        mdl_hi = e.hi;   mdl_lo = e.lo;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 64 && busy === 1'b1; k++) begin
            cnt++;
            n_checks++;
            if (hi !== old_hi || lo !== old_lo) begin
                n_fail++;
                $display("FAIL %s hold@%0d: hi=%h lo=%h, required hi=%h lo=%h",
                         name, cnt, hi, lo, old_hi, old_lo);
            end
            if (inj && cnt == 2) begin
                start = 1'b1; op = io; rs_val = ia; rt_val = ib;
            end else begin
                start = 1'b0; op = 3'($urandom_range(0, 5));
                rs_val = $urandom; rt_val = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (cnt !== e.cycles) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", e.name, cnt, e.cycles);
        end
        n_checks++;
        if (hi !== e.hi) begin
            n_fail++;
            $display("FAIL %s hi: got %h, required %h", e.name, hi, e.hi);
        end
        n_checks++;
        if (lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s lo: got %h, required %h", e.name, lo, e.lo);
        end
        $display("[TB] %s: busy=%0d cycles hi=%h lo=%h", e.name, cnt, hi, lo);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
        end
        $display("[TB] reset: busy=%b hi=%h lo=%h", busy, hi, lo);
        reset = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
    endtask

    task automatic test_mult();
        run_op("MULT -2*3", 3'd0, 32'hFFFF_FFFE, 32'd3);
        run_op("MULTU max*max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MULT -1*min", 3'd0, 32'hFFFF_FFFF, 32'h8000_0000);
    endtask

    task automatic test_div();
        run_op("DIV -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("DIVU 7/0", 3'd3, 32'd7, 32'd0);
        run_op("DIV 5/0", 3'd2, 32'd5, 32'd0);
        run_op("DIV min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("DIV 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE);
        run_op("DIVU big/7", 3'd3, 32'hF000_0001, 32'd7);
    endtask

    task automatic test_mthi_mtlo();
        run_op("MTHI", 3'd4, 32'h1234_5678, 32'd0);
        run_op("MULT 1000*1000 +MTLO", 3'd0, 32'd1000, 32'd1000, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        run_op("MTLO", 3'd5, 32'hCAFE_F00D, 32'd0);
    endtask

    task automatic test_noop();
        run_op("NOP 110", 3'd6, 32'h1111_1111, 32'h2222_2222);
        run_op("NOP 111", 3'd7, 32'h3333_3333, 32'h4444_4444);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 3));
            run_op($sformatf("B2B%0d op%0d", i, o), o, $urandom, $urandom | 32'd1);
        end
    endtask

    task automatic test_busy_ignore();
        run_op("MULT 6*7 +DIV", 3'd0, 32'd6, 32'd7, 1'b1, 3'd2, 32'd100, 32'd10);
    endtask

    task automatic test_reset_during_run();
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_run busy_before: got %b, required 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_run abort: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
        end
        repeat (15) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_run late_wb: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
        end
        $display("[TB] reset during DIV: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_noop();
        test_back_to_back();
        test_busy_ignore();
        test_reset_during_run();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
